// File: rtl/ib_counter_n.sv
`default_nettype none
// ============================================================================
// Module   : ib_counter_n
// Purpose  : Parametrised multi-mode benchmark counter. Counts up or down
//            through 0..i_limit. At the boundary it either wraps or
//            saturates. A prescaler gates the steps, and the counter has a
//            synchronous load, a one-cycle terminal-count pulse and a sticky
//            overflow flag.
// Ports    : i_clk       clock (rising edge)
//            i_rst       synchronous active-high reset
//            i_en        count enable (gates prescaler and counter)
//            i_dir       0 = up, 1 = down
//            i_sat       0 = wrap, 1 = saturate at boundary
//            i_limit     top of count range
//            i_div       prescale, one step per i_div+1 enabled cycles
//            i_load      synchronous load strobe
//            i_load_val  value loaded on i_load
//            i_clr_ovf   clears o_ovf (a simultaneous boundary wins)
//            o_c         count value (registered)
//            o_tc        terminal-count pulse (registered)
//            o_ovf       sticky boundary flag (registered)
//            o_zero      o_c == 0, decoded from the count register
// Revision : 1.0 - initial release
// ============================================================================
module ib_counter_n #(
  parameter int WIDTH = 8,
  parameter int PW    = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_en,
  input  logic             i_dir,
  input  logic             i_sat,
  input  logic [WIDTH-1:0] i_limit,
  input  logic [PW-1:0]    i_div,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_val,
  input  logic             i_clr_ovf,
  output logic [WIDTH-1:0] o_c,
  output logic             o_tc,
  output logic             o_ovf,
  output logic             o_zero
);

  logic [WIDTH-1:0] cnt;
  logic [PW-1:0]    pre;
  logic             tc;
  logic             ovf;

  logic [WIDTH-1:0] step_val;
  logic             boundary;
  logic             step_now;

  // A step qualifies only on an enabled cycle whose prescaler has reached
  // i_div. Because the test is equality, a p value already above a reduced
  // i_div keeps counting and wraps through 2^PW before it matches again.
  assign step_now = i_en && (pre == i_div);

  // Next count value for a qualifying step. Up-counting compares against
  // i_limit with >=, so a loaded value above the limit is treated as a
  // boundary. Down-counting only treats 0 as a boundary, so a value above
  // the limit simply decrements.
  always_comb begin
    step_val = cnt;
    boundary = 1'b0;
    if (!i_dir) begin
      if (cnt >= i_limit) begin
        boundary = 1'b1;
        step_val = i_sat ? i_limit : '0;
      end else begin
        step_val = cnt + WIDTH'(1);
      end
    end else begin
      if (cnt == '0) begin
        boundary = 1'b1;
        step_val = i_sat ? '0 : i_limit;
      end else begin
        step_val = cnt - WIDTH'(1);
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt <= '0;
      pre <= '0;
      tc  <= 1'b0;
      ovf <= 1'b0;
    end else if (i_load) begin
      cnt <= i_load_val;
      pre <= '0;
      tc  <= 1'b0;
      if (i_clr_ovf) ovf <= 1'b0;
    end else begin
      tc <= 1'b0;
      if (i_clr_ovf) ovf <= 1'b0;
      if (i_en) begin
        if (step_now) begin
          pre <= '0;
          cnt <= step_val;
          if (boundary) begin
            tc  <= 1'b1;
            // Placed after the clear so a same-edge boundary wins.
            ovf <= 1'b1;
          end
        end else begin
          pre <= pre + PW'(1);
        end
      end
    end
  end

  assign o_c    = cnt;
  assign o_tc   = tc;
  assign o_ovf  = ovf;
  assign o_zero = (cnt == '0);

endmodule
`default_nettype wire

// File: tb/tb_ib_counter_n.sv
`default_nettype none
// ============================================================================
// Module   : tb_ib_counter_n
// Purpose  : Directed self-checking bench for ib_counter_n (WIDTH=8, PW=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_ib_counter_n;

  logic       clk = 1'b0;
  logic       rst, en, dir, sat, load, clr_ovf;
  logic [7:0] limit, load_val;
  logic [3:0] div;
  logic [7:0] c;
  logic       tc, ovf, zero;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  ib_counter_n #(.WIDTH(8), .PW(4)) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_en       (en),
    .i_dir      (dir),
    .i_sat      (sat),
    .i_limit    (limit),
    .i_div      (div),
    .i_load     (load),
    .i_load_val (load_val),
    .i_clr_ovf  (clr_ovf),
    .o_c        (c),
    .o_tc       (tc),
    .o_ovf      (ovf),
    .o_zero     (zero)
  );

  task automatic check_val(input string tag, input logic [31:0] obs,
                           input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance n clock edges; inputs and samples change 1 ns after the edge.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b0; dir = 1'b0; sat = 1'b0; load = 1'b0;
    clr_ovf = 1'b0; limit = 8'hFF; div = 4'd0; load_val = 8'h00;
    tick(1);
    rst = 1'b0;
  endtask

  initial begin
    do_reset();
    check_val("rst_c", c, 0);
    check_val("rst_tc", tc, 0);
    check_val("rst_ovf", ovf, 0);
    check_val("rst_zero", zero, 1);

    // 1. reset mid-run: build o_c=0x37, ovf=1, p=2 then reset
    limit = 8'h00; en = 1'b1; tick(1);          // limit 0 -> boundary
    check_val("lim0_c", c, 0);
    check_val("lim0_tc", tc, 1);
    check_val("lim0_ovf", ovf, 1);
    en = 1'b0; load = 1'b1; load_val = 8'h37; tick(1);
    load = 1'b0; limit = 8'hFF; div = 4'd3; en = 1'b1; tick(2);
    check_val("pre_c", c, 8'h37);
    check_val("pre_ovf", ovf, 1);
    rst = 1'b1; load = 1'b1; load_val = 8'h11; tick(1);
    check_val("mid_rst_c", c, 0);
    check_val("mid_rst_tc", tc, 0);
    check_val("mid_rst_ovf", ovf, 0);
    check_val("mid_rst_zero", zero, 1);
    rst = 1'b0; load = 1'b0; tick(3);
    check_val("rst_pre3", c, 0);
    tick(1);
    check_val("rst_pre4", c, 1);
    check_val("rst_pre4_zero", zero, 0);

    // 2. free-run wrap over the full range
    do_reset();
    en = 1'b1;
    for (int i = 1; i <= 255; i++) begin
      tick(1);
      check_val("free_c", c, i);
      check_val("free_tc", tc, 0);
    end
    check_val("free_ovf_pre", ovf, 0);
    tick(1);
    check_val("wrap_c", c, 0);
    check_val("wrap_tc", tc, 1);
    check_val("wrap_ovf", ovf, 1);
    check_val("wrap_zero", zero, 1);
    tick(1);
    check_val("wrap_next_c", c, 1);
    check_val("wrap_next_tc", tc, 0);

    // 3. modulo-10 saturate
    do_reset();
    limit = 8'd9; sat = 1'b1; en = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      tick(1);
      check_val("sat_c", c, i);
      check_val("sat_tc", tc, 0);
    end
    tick(1);
    check_val("sat_hold_c", c, 9);
    check_val("sat_hold_tc", tc, 1);
    check_val("sat_hold_ovf", ovf, 1);
    tick(1);
    check_val("sat_hold2_c", c, 9);
    check_val("sat_hold2_tc", tc, 1);

    // 4. down wrap with prescale
    do_reset();
    limit = 8'd5; div = 4'd3; dir = 1'b1; en = 1'b1;
    tick(3);
    check_val("dn_wait_c", c, 0);
    tick(1);
    check_val("dn_wrap_c", c, 5);
    check_val("dn_wrap_tc", tc, 1);
    tick(1);
    check_val("dn_tc_off", tc, 0);
    tick(3);
    check_val("dn_c4", c, 4);
    tick(2);                                    // p = 2
    en = 1'b0; tick(3);
    check_val("dn_hold_c", c, 4);
    en = 1'b1; tick(1);
    check_val("dn_stretch_c", c, 4);
    tick(1);
    check_val("dn_stretch_step", c, 3);

    // 5. load priority over a would-be boundary step
    do_reset();
    limit = 8'd9; div = 4'd0;
    load = 1'b1; load_val = 8'd9; tick(1);
    en = 1'b1; load_val = 8'hA5; tick(1);
    check_val("ld_c", c, 8'hA5);
    check_val("ld_tc", tc, 0);
    check_val("ld_ovf", ovf, 0);
    load_val = 8'hF0; tick(1);
    load = 1'b0; tick(1);
    check_val("ld_over_c", c, 0);
    check_val("ld_over_tc", tc, 1);
    load = 1'b1; tick(1);
    load = 1'b0; dir = 1'b1; tick(1);
    check_val("ld_dn_c", c, 8'hEF);
    check_val("ld_dn_tc", tc, 0);

    // 6. overflow clear
    do_reset();
    limit = 8'd9; load = 1'b1; load_val = 8'd9; tick(1);
    load = 1'b0; en = 1'b1; clr_ovf = 1'b1; tick(1);
    check_val("clr_same_ovf", ovf, 1);
    check_val("clr_same_c", c, 0);
    en = 1'b0; tick(1);
    check_val("clr_ovf", ovf, 0);
    check_val("clr_c", c, 0);
    check_val("clr_tc", tc, 0);
    clr_ovf = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
